mem_bus_if: RTL and testbench

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if_pkg.sv | 38 +++
 rtl/mem_bus_if_load_align.sv | 42 ++++
 rtl/mem_bus_if.sv | 155 +++++++++++++++
 tb/tb_mem_bus_if.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the MEM-stage bus interface.
// Holds the size codes, the FSM state encoding, the default timeout and the byte-lane helpers.
package mem_bus_if_pkg;

  localparam int TIMEOUT_DEF = 255;

  // raw_flag size codes; 2'b11 falls through to word everywhere
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_bus_if_load_align.sv
// Load lane selection: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it to the full data width.
module load_align
  import mem_bus_if_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              load_signed,
  output logic [DATA_W-1:0] data
);

  localparam int LANE_W = DATA_W / 4;

  logic [LANE_W-1:0]   byte_s;
  logic [2*LANE_W-1:0] half_s;

  // lane extraction and extension
  always_comb begin
    byte_s = rdata[LANE_W-1:0];
    case (addr_lo)
      2'b00:   byte_s = rdata[LANE_W-1:0];
      2'b01:   byte_s = rdata[2*LANE_W-1:LANE_W];
      2'b10:   byte_s = rdata[3*LANE_W-1:2*LANE_W];
      2'b11:   byte_s = rdata[DATA_W-1:3*LANE_W];
      default: byte_s = rdata[LANE_W-1:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[DATA_W-1:2*LANE_W];
    end else begin
      half_s = rdata[2*LANE_W-1:0];
    end
    case (size)
      SZ_BYTE: data = {{(DATA_W-LANE_W){load_signed & byte_s[LANE_W-1]}}, byte_s};
      SZ_HALF: data = {{(DATA_W-2*LANE_W){load_signed & half_s[2*LANE_W-1]}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_if.sv
// MEM-stage load/store bridge to a req/ack memory bus. Stalls the pipeline while a
// bus transfer is outstanding and aborts with bus_err after TIMEOUT unacknowledged cycles.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wite_mem,
  input  logic              read_mem,
  input  logic [1:0]        raw_flag,
  input  logic              load_signed,
  input  logic [ADDR_W-1:0] raw_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int LANE_W = DATA_W / 4;

  state_e              state_r, state_nxt_s;
  logic                req_s, mis_s, accept_s, timeout_s, stall_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          size_r, addr_lo_r;
  logic                sign_r, misalign_r, bus_err_r, bus_we_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [3:0]          bus_be_r;
  logic [DATA_W-1:0]   bus_wdata_r, store_wdata_s, align_data_s, data_out_r;

  assign req_s = wite_mem | read_mem;
  assign mis_s = is_misaligned(raw_flag, raw_addr[1:0]);

  // store-data lane replication
  always_comb begin
    case (raw_flag)
      SZ_BYTE: store_wdata_s = {4{data_in[LANE_W-1:0]}};
      SZ_HALF: store_wdata_s = {2{data_in[2*LANE_W-1:0]}};
      default: store_wdata_s = data_in;
    endcase
  end

  // FSM next state, stall and abort decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    timeout_s   = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s && !mis_s) begin
          accept_s    = 1'b1;
          stall_s     = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (bus_ack) begin
          state_nxt_s = ST_DONE;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // request latches, wait counter, load result and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      size_r      <= 2'b00;
      addr_lo_r   <= 2'b00;
      sign_r      <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= {DATA_W{1'b0}};
      data_out_r  <= {DATA_W{1'b0}};
      misalign_r  <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        size_r      <= raw_flag;
        addr_lo_r   <= raw_addr[1:0];
        sign_r      <= load_signed;
        bus_we_r    <= wite_mem;
        bus_addr_r  <= {raw_addr[ADDR_W-1:2], 2'b00};
        bus_be_r    <= byte_en(raw_flag, raw_addr[1:0]);
        bus_wdata_r <= store_wdata_s;
      end
      if (state_r == ST_REQ && !bus_ack && !timeout_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
      // result is only non-zero for the DONE cycle of an acknowledged load
      if (state_r == ST_REQ && bus_ack && !bus_we_r) begin
        data_out_r <= align_data_s;
      end else begin
        data_out_r <= {DATA_W{1'b0}};
      end
      misalign_r <= (state_r == ST_IDLE) && req_s && mis_s;
      bus_err_r  <= timeout_s;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata       (bus_rdata),
    .addr_lo     (addr_lo_r),
    .size        (size_r),
    .load_signed (sign_r),
    .data        (align_data_s)
  );

  // IDLE-cycle stall is combinational, so it must also drop the instant reset asserts
  assign stall     = stall_s & reset;
  assign bus_req   = (state_r == ST_REQ);
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_be    = bus_be_r;
  assign bus_wdata = bus_wdata_r;
  assign data_out  = data_out_r;
  assign misalign  = misalign_r;
  assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: directed scenarios plus randomized accesses
// compared against a byte-arithmetic reference model.
module tb_mem_bus_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wite_mem, read_mem, load_signed, bus_ack;
  logic [1:0]  raw_flag;
  logic [31:0] raw_addr, data_in, bus_rdata;
  logic [31:0] data_out, bus_addr, bus_wdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_pass   = 0;

  int          o_stall, o_req, o_mis, o_err;
  logic [31:0] o_dout, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we, o_unstable, o_done;

  always #5 clk = ~clk;

  mem_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .wite_mem(wite_mem), .read_mem(read_mem),
    .raw_flag(raw_flag), .load_signed(load_signed), .raw_addr(raw_addr),
    .data_in(data_in), .data_out(data_out), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Reference: sizes in bytes, lanes by shifting, extension by masking.
  function automatic void model(input logic we, input logic [1:0] flg, input logic sgn,
      input logic [31:0] addr, input logic [31:0] din, input logic [31:0] rdw, input int dly,
      output int e_mis, output int e_req, output int e_stall, output int e_err,
      output logic [31:0] e_dout, output logic [3:0] e_be, output logic [31:0] e_wdata);
    int n, off;
    logic [31:0] mask, v;
    n   = (flg == 2'b10) ? 1 : (flg == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    e_be = 4'((1 << n) - 1) << off;
    if (n == 1)      e_wdata = {24'h0, din[7:0]} * 32'h01010101;
    else if (n == 2) e_wdata = {16'h0, din[15:0]} * 32'h00010001;
    else             e_wdata = din;
    e_mis = ((off % n) != 0) ? 1 : 0;
    if (e_mis == 1) begin
      e_req = 0; e_stall = 0; e_err = 0; e_dout = 32'h0;
    end else begin
      e_req   = (dly < TMO) ? dly + 1 : TMO;
      e_err   = (dly < TMO) ? 0 : 1;
      e_stall = e_req + 1;
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
      v = (rdw >> (8 * off)) & mask;
      if (sgn && n < 4 && v[8*n-1]) v = v | ~mask;
      e_dout = (we || e_err == 1) ? 32'h0 : v;
    end
  endfunction

  // Drive one MEM-stage access (held while stalled), answer the bus, record what happened.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_access(input logic we, input logic rd, input logic [1:0] flg, input logic sgn,
      input logic [31:0] addr, input logic [31:0] din, input int dly, input logic [31:0] rdw,
      input int tail);
    logic seen;
    seen = 1'b0;
    o_stall = 0; o_req = 0; o_mis = 0; o_err = 0; o_done = 1'b0;
    o_dout = 32'h0; o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0; o_unstable = 1'b0;
    wite_mem = we; read_mem = rd; raw_flag = flg; load_signed = sgn;
    raw_addr = addr; data_in = din; bus_ack = 1'b0;
    for (int c = 0; c < 40 && !o_done; c++) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (misalign) o_mis++;
      if (bus_err) o_err++;
      if (bus_req) begin
        if (o_req == 0) begin
          o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
        end else if (bus_be !== o_be || bus_addr !== o_addr || bus_wdata !== o_wdata || bus_we !== o_we) begin
          o_unstable = 1'b1;
        end
        bus_ack   = (o_req == dly);
        bus_rdata = bus_ack ? rdw : $urandom;
        o_req++;
        seen = 1'b1;
      end else begin
        bus_ack = 1'b0;
        if (seen || !stall) begin
          o_dout = data_out;
          o_done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    wite_mem = 1'b0; read_mem = 1'b0; bus_ack = 1'b0;
    for (int c = 0; c < tail; c++) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (misalign) o_mis++;
      if (bus_err) o_err++;
      if (bus_req) o_req++;
    end
    if (tail > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wite_mem = 1'b0; read_mem = 1'b1; raw_flag = 2'b00; load_signed = 1'b0;
    raw_addr = 32'h10; data_in = 32'h1234_5678; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_req !== 1'b0 || stall !== 1'b0) $display("FAIL reset_req_stall: got %b%b want 00", bus_req, stall); else n_pass++;
    n_checks++; if (data_out !== 32'h0) $display("FAIL reset_dout: got %h want 00000000", data_out); else n_pass++;
    n_checks++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) $display("FAIL reset_bus: got we=%b be=%b addr=%h wd=%h want zeros", bus_we, bus_be, bus_addr, bus_wdata); else n_pass++;
    n_checks++; if (misalign !== 1'b0 || bus_err !== 1'b0) $display("FAIL reset_pulses: got %b%b want 00", misalign, bus_err); else n_pass++;
    @(posedge clk); #1;
    read_mem = 1'b0; bus_ack = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 0);
    n_checks++; if (o_stall !== 2) $display("FAIL word_load_stall: got %0d want 2", o_stall); else n_pass++;
    n_checks++; if (o_dout !== 32'hDEAD_BEEF) $display("FAIL word_load_dout: got %h want deadbeef", o_dout); else n_pass++;
    n_checks++; if (o_be !== 4'b1111) $display("FAIL word_load_be: got %b want 1111", o_be); else n_pass++;
    run_access(1'b0, 1'b1, 2'b10, 1'b1, 32'h13, 32'h0, 1, 32'h8011_2233, 0);
    n_checks++; if (o_be !== 4'b1000) $display("FAIL sbyte_be: got %b want 1000", o_be); else n_pass++;
    n_checks++; if (o_dout !== 32'hFFFF_FF80) $display("FAIL sbyte_dout: got %h want ffffff80", o_dout); else n_pass++;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h0, 0, 32'h8011_2233, 0);
    n_checks++; if (o_dout !== 32'h0000_0080) $display("FAIL ubyte_dout: got %h want 00000080", o_dout); else n_pass++;
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 0, 32'h0, 0);
    n_checks++; if (o_we !== 1'b1 || o_be !== 4'b1100) $display("FAIL half_store_we_be: got %b/%b want 1/1100", o_we, o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'hABCD_ABCD) $display("FAIL half_store_wdata: got %h want abcdabcd", o_wdata); else n_pass++;
    n_checks++; if (o_addr !== 32'h20) $display("FAIL half_store_addr: got %h want 00000020", o_addr); else n_pass++;
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h05, 32'h0, 0, 32'h0, 2);
    n_checks++; if (o_mis !== 1) $display("FAIL misalign_pulse: got %0d want 1", o_mis); else n_pass++;
    n_checks++; if (o_req !== 0 || o_stall !== 0) $display("FAIL misalign_noreq: got req=%0d stall=%0d want 0/0", o_req, o_stall); else n_pass++;
    run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h31, 32'h0000_005A, 0, 32'h0, 0);
    n_checks++; if (o_we !== 1'b1 || o_wdata !== 32'h5A5A_5A5A) $display("FAIL both_is_store: got we=%b wd=%h want 1/5a5a5a5a", o_we, o_wdata); else n_pass++;
  endtask

  task automatic test_timeout();
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, 99, 32'h0, 1);
    n_checks++; if (o_req !== TMO) $display("FAIL timeout_req_cycles: got %0d want %0d", o_req, TMO); else n_pass++;
    n_checks++; if (o_err !== 1) $display("FAIL timeout_err_pulse: got %0d want 1", o_err); else n_pass++;
    n_checks++; if (o_dout !== 32'h0) $display("FAIL timeout_dout: got %h want 00000000", o_dout); else n_pass++;
    n_checks++; if (o_stall !== TMO + 1) $display("FAIL timeout_stall: got %0d want %0d", o_stall, TMO + 1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    wite_mem = 1'b0; read_mem = 1'b1; raw_flag = 2'b00; load_signed = 1'b0; raw_addr = 32'h44;
    w = 0;
    do begin
      @(negedge clk); w++;
    end while (!bus_req && w < 5);
    n_checks++; if (bus_req !== 1'b1) $display("FAIL rstmid_reach_req: got %b want 1", bus_req); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0 || stall !== 1'b0) $display("FAIL rstmid_immediate: got req=%b stall=%b want 0/0", bus_req, stall); else n_pass++;
    n_checks++; if (bus_addr !== 32'h0 || bus_be !== 4'h0) $display("FAIL rstmid_bus_clear: got %h/%b want 0/0", bus_addr, bus_be); else n_pass++;
    @(posedge clk); #1;
    read_mem = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    run_access(1'b0, 1'b1, 2'b01, 1'b1, 32'h56, 32'h0, 0, 32'h9ABC_1234, 0);
    n_checks++; if (o_req !== 1 || o_dout !== 32'hFFFF_9ABC) $display("FAIL rstmid_after: got req=%0d dout=%h want 1/ffff9abc", o_req, o_dout); else n_pass++;
  endtask

  task automatic test_ack_outside_req();
    int bad;
    bad = 0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    repeat (4) begin
      @(negedge clk);
      if (bus_req !== 1'b0 || stall !== 1'b0 || data_out !== 32'h0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL stray_ack: got %0d disturbed cycles want 0", bad); else n_pass++;
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  task automatic test_random();
    logic we, rd, sgn;
    logic [1:0] flg;
    logic [31:0] addr, din, rdw, e_dout, e_wdata;
    logic [3:0] e_be;
    int op, dly, tail, e_mis, e_req, e_stall, e_err;
    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 2);
      we  = (op != 0);
      rd  = (op != 1);
      flg = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      addr = $urandom & 32'h0000_FFFF;
      din = $urandom; rdw = $urandom;
      dly = ($urandom_range(0, 4) == 0) ? 99 : $urandom_range(0, TMO);
      model(we, flg, sgn, addr, din, rdw, dly, e_mis, e_req, e_stall, e_err, e_dout, e_be, e_wdata);
      tail = (e_mis == 1) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      run_access(we, rd, flg, sgn, addr, din, dly, rdw, tail);
      n_checks++; if (o_mis !== e_mis) $display("FAIL rand_mis #%0d: got %0d want %0d", i, o_mis, e_mis); else n_pass++;
      n_checks++; if (o_req !== e_req) $display("FAIL rand_req #%0d: got %0d want %0d", i, o_req, e_req); else n_pass++;
      n_checks++; if (o_stall !== e_stall) $display("FAIL rand_stall #%0d: got %0d want %0d", i, o_stall, e_stall); else n_pass++;
      n_checks++; if (o_err !== e_err) $display("FAIL rand_err #%0d: got %0d want %0d", i, o_err, e_err); else n_pass++;
      n_checks++; if (o_dout !== e_dout) $display("FAIL rand_dout #%0d: got %h want %h", i, o_dout, e_dout); else n_pass++;
      if (e_mis == 0) begin
        n_checks++; if (o_be !== e_be) $display("FAIL rand_be #%0d: got %b want %b", i, o_be, e_be); else n_pass++;
        n_checks++; if (o_addr !== {addr[31:2], 2'b00}) $display("FAIL rand_addr #%0d: got %h want %h", i, o_addr, {addr[31:2], 2'b00}); else n_pass++;
        n_checks++; if (o_wdata !== e_wdata) $display("FAIL rand_wdata #%0d: got %h want %h", i, o_wdata, e_wdata); else n_pass++;
        n_checks++; if (o_we !== we || o_unstable !== 1'b0) $display("FAIL rand_we_stable #%0d: got we=%b unstable=%b want %b/0", i, o_we, o_unstable, we); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h80, 32'h0, 0, 32'h1111_2222, 0);
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h82, 32'h0, 0, 32'h0077_0000, 0);
    n_checks++; if (o_req !== 1 || o_dout !== 32'h0000_0077) $display("FAIL b2b_second: got req=%0d dout=%h want 1/00000077", o_req, o_dout); else n_pass++;
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h84, 32'h0BAD_F00D, 2, 32'h0, 0);
    n_checks++; if (o_req !== 3 || o_wdata !== 32'h0BAD_F00D || o_dout !== 32'h0) $display("FAIL b2b_store: got req=%0d wd=%h dout=%h want 3/0badf00d/0", o_req, o_wdata, o_dout); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_ack_outside_req();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
